if_prefetch_buf: RTL and testbench
==================================

// Module: if_prefetch_buf
// PURPOSE
//  Instruction prefetch queue between the imem read port and the f1/id decode stage of CoNM.
//  Captures {inst_addr, inst} responses from imem and presents them first-word-fall-through to decode.
//  Throttles the PC stage, and flushes on a redirect from the extl stage (jump).
//  Decouples fetch from decode stalls, so imem runs back-to-back while decode holds.
// PARAMETERS
//  DEPTH    4             queue entries; power of two, >= 2
//  ADDR_W   32            inst address width; matches `INST_ADDR_WIDTH
//  INST_W   32            instruction width; matches `INST_WIDTH
//  NOP_INST 32'h00000013  word driven on id_inst_o when the queue is empty (addi x0,x0,0)
// PORTS
//  clk            in   1       core clock
//  rst            in   1       reset; asynchronous, active-low (`RST == 1'b0)
//  fetch_ready_o  out  1       PC stage may issue an imem request this cycle
//  fetch_valid_i  in   1       imem response valid; arrives 1 cycle after the request
//  fetch_addr_i   in   ADDR_W  address of the response
//  fetch_inst_i   in   INST_W  instruction word of the response
//  id_valid_o     out  1       head entry valid
//  id_inst_addr_o out  ADDR_W  head address (0 when empty)
//  id_inst_o      out  INST_W  head instruction (NOP_INST when empty)
//  id_ready_i     in   1       decode accepts the head this cycle
//  flush_i        in   1       extl_jump: discard all queued and in-flight instructions
//  count_o        out  log2(DEPTH)+1  current occupancy
//  overflow_o     out  1       sticky error: response arrived while full
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr = 0, rd_ptr = 0, count_o = 0, drop = 0, overflow_o = 0.
//    Output values under reset: id_valid_o = 0, fetch_ready_o = 1.
//  - Reset asserted mid-operation clears everything immediately; payload RAM contents are don't-care.
//  - Pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the LSBs match.
//    Empty when the pointers are equal.
//  - Push = fetch_valid_i & !flush_i & !drop & !full. Pop = id_valid_o & id_ready_i & !flush_i.
//  - Latency: a push in cycle N is visible on id_* in cycle N+1. There is no same-cycle bypass when empty.
//  - id_* are combinational from the head entry. id_valid_o = !empty.
//  - fetch_ready_o = (count_o <= DEPTH-2). This leaves one slot for the response already in flight.
//    Combinational from count_o only; no dependency on id_ready_i.
//  - Push and pop in the same cycle: both take effect and count_o is unchanged. This also holds when full,
//    but fetch_ready_o gating normally prevents a full-queue response.
//  - A response while full with no pop is discarded and sets overflow_o (sticky until reset).
//  - Flush: has priority over push and pop. Next cycle rd_ptr = wr_ptr and count_o = 0.
//    Sets drop = 1 for exactly one cycle, so the stale response for the request issued during the flush
//    cycle is discarded.
//  - Back-to-back flush: drop stays asserted through the cycle after the last flush.
//  - After a flush, the first accepted entry is the response to the redirected PC (2 cycles after flush_i).
//  - overflow_o is not cleared by flush.
// STRUCTURE
//  - Widths, NOP_INST and the `RST/`UNRST polarity macros come from the shared defines.v.
//    Add `PFB_DEPTH there.
//  - One sub-module: pfb_ram (DEPTH x (ADDR_W+INST_W)). Sync write, async read, no reset on storage.
//  - The top level holds pointers, the drop flag, the overflow flag and all handshake logic.
// TESTING
//  1. Reset low for 40 ns, then release -> id_valid_o=0, id_inst_o=0x00000013, fetch_ready_o=1, count_o=0.
//  2. Push 0x0/0x00500093, 0x4/0x00100113 with id_ready_i=0 -> count_o=2, fetch_ready_o=1.
//     Head = 0x0/0x00500093 one cycle after the first push.
//  3. Fill with id_ready_i=0 -> fetch_ready_o drops at count_o=3. In-flight response reaches count_o=4.
//     overflow_o stays 0.
//  4. Full queue, then id_ready_i=1 and fetch_valid_i=1 in the same cycle -> count_o stays 4.
//     Head advances by one; FIFO order is preserved across pointer wrap (8+ pushes).
//  5. count_o=3, flush_i=1 with fetch_valid_i=1 -> next cycle count_o=0, id_valid_o=0.
//     Response in the flush+1 cycle (0x10) is dropped. Response 0x80 in the flush+2 cycle becomes the head.
//  6. Force fetch_valid_i while full with id_ready_i=0 -> overflow_o=1 and stays 1 through a flush.
//     Cleared only by rst=0.

Source files
------------

// File: rtl/if_prefetch_buf_pkg.sv
// Shared constants for the instruction prefetch buffer between imem and decode.
// Widths follow the core's instruction address/word sizes.
package if_prefetch_buf_pkg;

    localparam int unsigned PFB_DEPTH    = 4;
    localparam int unsigned PFB_ADDR_W   = 32;
    localparam int unsigned PFB_INST_W   = 32;
    localparam logic [31:0] PFB_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/pfb_ram.sv
// Payload storage for the prefetch queue: synchronous write, asynchronous read.
module pfb_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers, so a reset here only costs area.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch queue: captures imem responses, presents them first-word-fall-through
// to decode, throttles the PC stage and flushes on a jump redirect.
module if_prefetch_buf
    import if_prefetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH    = PFB_DEPTH,
    parameter int unsigned ADDR_W   = PFB_ADDR_W,
    parameter int unsigned INST_W   = PFB_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(PFB_NOP_INST),
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned PTR_W    = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_ready_o,
    input  logic              fetch_valid_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic [INST_W-1:0] fetch_inst_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_inst_addr_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    input  logic              flush_i,
    output logic [PTR_W-1:0]  count_o,
    output logic              overflow_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             drop_q, drop_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, push, pop, resp_ok;
    logic [ADDR_W+INST_W-1:0] head;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign pop     = !empty && id_ready_i && !flush_i;
    assign resp_ok = fetch_valid_i && !flush_i && !drop_q;
    // A full queue still accepts a response when the head leaves in the same cycle.
    assign push    = resp_ok && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_d     = flush_i;
        overflow_d = overflow_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (resp_ok && full && !pop) overflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    pfb_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i ({fetch_addr_i, fetch_inst_i}),
        .raddr_i (rd_ptr_q[IDX_W-1:0]),
        .rdata_o (head)
    );

    assign id_valid_o     = !empty;
    assign id_inst_addr_o = empty ? '0 : head[ADDR_W+INST_W-1:INST_W];
    assign id_inst_o      = empty ? NOP_INST : head[INST_W-1:0];
    // Leaves one free slot for the response to a request issued this cycle.
    assign fetch_ready_o  = (count_o <= PTR_W'(DEPTH - 2));
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf: reset, fill/throttle, full push+pop across wrap,
// flush with drop window, back-to-back flush, and sticky overflow.
module tb_if_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready_o;
    logic        fetch_valid_i;
    logic [31:0] fetch_addr_i;
    logic [31:0] fetch_inst_i;
    logic        id_valid_o;
    logic [31:0] id_inst_addr_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
    logic        flush_i;
    logic [2:0]  count_o;
    logic        overflow_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_prefetch_buf dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ready_o  (fetch_ready_o),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_inst_i   (fetch_inst_i),
        .id_valid_o     (id_valid_o),
        .id_inst_addr_o (id_inst_addr_o),
        .id_inst_o      (id_inst_o),
        .id_ready_i     (id_ready_i),
        .flush_i        (flush_i),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Apply one cycle of inputs, clock it, then settle before the caller samples.
    task automatic cyc(input logic fv, input logic [31:0] a, input logic [31:0] i,
                       input logic rdy, input logic fl);
        fetch_valid_i = fv;
        fetch_addr_i  = a;
        fetch_inst_i  = i;
        id_ready_i    = rdy;
        flush_i       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] i);
        check({tag, "_valid"}, 64'(id_valid_o), 64'd1);
        check({tag, "_addr"},  64'(id_inst_addr_o), 64'(a));
        check({tag, "_inst"},  64'(id_inst_o), 64'(i));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 64'(id_valid_o), 64'd0);
        check({tag, "_addr"},  64'(id_inst_addr_o), 64'd0);
        check({tag, "_inst"},  64'(id_inst_o), 64'h13);
        check({tag, "_count"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        rst           = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_addr_i  = '0;
        fetch_inst_i  = '0;
        id_ready_i    = 1'b0;
        flush_i       = 1'b0;

        // 1. reset
        #20;
        check("rst_valid", 64'(id_valid_o), 64'd0);
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        #20;
        rst = 1'b1;
        #1;
        check_empty("post_rst");
        check("post_rst_ready", 64'(fetch_ready_o), 64'd1);
        check("post_rst_ovf", 64'(overflow_o), 64'd0);

        // 2. two pushes, decode stalled
        cyc(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        check_head("push0", 32'h0, 32'h0050_0093);
        check("push0_count", 64'(count_o), 64'd1);
        cyc(1'b1, 32'h4, 32'h0010_0113, 1'b0, 1'b0);
        check_head("push1", 32'h0, 32'h0050_0093);
        check("push1_count", 64'(count_o), 64'd2);
        check("push1_ready", 64'(fetch_ready_o), 64'd1);

        // 3. fill: throttle at 3, in-flight response lands at 4
        cyc(1'b1, 32'h8, inst_of(32'h8), 1'b0, 1'b0);
        check("fill3_count", 64'(count_o), 64'd3);
        check("fill3_ready", 64'(fetch_ready_o), 64'd0);
        cyc(1'b1, 32'hC, inst_of(32'hC), 1'b0, 1'b0);
        check("fill4_count", 64'(count_o), 64'd4);
        check("fill4_ready", 64'(fetch_ready_o), 64'd0);
        check("fill4_ovf", 64'(overflow_o), 64'd0);
        check_head("fill4", 32'h0, 32'h0050_0093);

        // 4. full with simultaneous push and pop, repeated across pointer wrap
        cyc(1'b1, 32'h10, inst_of(32'h10), 1'b1, 1'b0);
        check("pp_count", 64'(count_o), 64'd4);
        check_head("pp", 32'h4, 32'h0010_0113);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] h;
            a = 32'h14 + 32'(4 * k);
            h = 32'h8 + 32'(4 * k);
            cyc(1'b1, a, inst_of(a), 1'b1, 1'b0);
            check_head($sformatf("wrap%0d", k), h, inst_of(h));
            check($sformatf("wrap%0d_count", k), 64'(count_o), 64'd4);
        end
        check("wrap_ovf", 64'(overflow_o), 64'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pop3_count", 64'(count_o), 64'd3);
        check_head("pop3", 32'h28, inst_of(32'h28));

        // 5. flush at count 3 with a response in the flush cycle
        cyc(1'b1, 32'h34, inst_of(32'h34), 1'b0, 1'b1);
        check_empty("flush");
        check("flush_ready", 64'(fetch_ready_o), 64'd1);
        cyc(1'b1, 32'h10, inst_of(32'h10), 1'b0, 1'b0);
        check_empty("drop");
        cyc(1'b1, 32'h80, inst_of(32'h80), 1'b0, 1'b0);
        check_head("redir", 32'h80, inst_of(32'h80));
        check("redir_count", 64'(count_o), 64'd1);

        // back-to-back flush extends the drop window by one cycle past the last flush
        cyc(1'b1, 32'h40, inst_of(32'h40), 1'b0, 1'b1);
        cyc(1'b1, 32'h44, inst_of(32'h44), 1'b0, 1'b1);
        check_empty("bb_flush");
        cyc(1'b1, 32'h48, inst_of(32'h48), 1'b0, 1'b0);
        check_empty("bb_drop");
        cyc(1'b1, 32'h90, inst_of(32'h90), 1'b0, 1'b0);
        check_head("bb_redir", 32'h90, inst_of(32'h90));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_empty("drain");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_empty("pop_empty");

        // 6. forced response while full sets sticky overflow
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 32'hA0 + 32'(4 * k), inst_of(32'hA0 + 32'(4 * k)), 1'b0, 1'b0);
        end
        check("ovf_pre_count", 64'(count_o), 64'd4);
        check("ovf_pre", 64'(overflow_o), 64'd0);
        cyc(1'b1, 32'hB0, inst_of(32'hB0), 1'b0, 1'b0);
        check("ovf_set", 64'(overflow_o), 64'd1);
        check("ovf_count", 64'(count_o), 64'd4);
        check_head("ovf_head", 32'hA0, inst_of(32'hA0));
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("ovf_flush", 64'(overflow_o), 64'd1);
        check_empty("ovf_flush");
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ovf_hold", 64'(overflow_o), 64'd1);

        // mid-operation reset clears everything immediately
        cyc(1'b1, 32'hC0, inst_of(32'hC0), 1'b0, 1'b0);
        check("pre_rst_count", 64'(count_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst2_ovf", 64'(overflow_o), 64'd0);
        check_empty("rst2");
        check("rst2_ready", 64'(fetch_ready_o), 64'd1);
        #10;
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
